// File: rtl/slave_bus_reader.sv
// Slave-bus frame reader.
// Round-robin arbitrates among the slave-bus requesters, walks the granted
// requester's buffered frame by address until its end-of-frame marker word,
// streams the payload bytes downstream with source index and frame-end flag,
// and finally pulses sl_latch_tail so the requester retires the frame.
module slave_bus_reader #(
    parameter int NUM_REQ       = 4,
    parameter int SRC_W         = 2,
    parameter int MAX_FRAME_LEN = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] sl_arb_request,
    output logic [NUM_REQ-1:0] sl_arb_grant,
    output logic [8:0]         sl_addr,
    input  logic [8:0]         sl_data,
    input  logic [8:0]         sl_tail,
    output logic               sl_latch_tail,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SRC_W-1:0]   out_src,
    output logic               out_last,
    output logic               out_err
);

    localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_EOF    = 3'd3;
    localparam logic [2:0] ST_RETIRE = 3'd4;

    logic [2:0]         state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [8:0]         addr_r;
    logic [SRC_W-1:0]   src_r;
    logic [SRC_W-1:0]   rr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_r;
    logic               latch_r;

    logic               pick_found_s;
    logic [SRC_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic               marker_s;
    logic               cnt_full_s;
    logic               valid_s;
    logic               last_s;
    logic               err_s;
    logic [7:0]         data_s;
    logic               xfer_s;
    logic [SRC_W-1:0]   rr_next_s;

    // Round-robin search: first pending request at or above rr_r, wrapping.
    always_comb begin
        int cand;
        cand         = 0;
        pick_found_s = 1'b0;
        pick_idx_s   = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_r) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!pick_found_s && sl_arb_request[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = SRC_W'(cand);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // One-hot decode of the selected requester index.
    always_comb begin
        pick_grant_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_grant_s[i] = (pick_idx_s == SRC_W'(i));
        end
    end

    // Stream-side beat generation; the marker bit steers the FSM instead of
    // producing a payload beat, and a full counter forces termination.
    always_comb begin
        marker_s   = sl_data[8];
        cnt_full_s = (cnt_r == CNT_W'(MAX_FRAME_LEN));
        valid_s    = 1'b0;
        last_s     = 1'b0;
        err_s      = 1'b0;
        data_s     = 8'h00;
        case (state_r)
            ST_READ: begin
                if (!marker_s && !cnt_full_s) begin
                    valid_s = 1'b1;
                    data_s  = sl_data[7:0];
                end else begin
                    valid_s = 1'b0;
                end
            end
            ST_EOF: begin
                valid_s = 1'b1;
                last_s  = 1'b1;
                err_s   = err_r;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
        xfer_s = valid_s & out_ready;
    end

    // Pointer advance past the requester that just finished a frame.
    always_comb begin
        if (src_r == SRC_W'(NUM_REQ - 1)) begin
            rr_next_s = {SRC_W{1'b0}};
        end else begin
            rr_next_s = src_r + SRC_W'(1);
        end
    end

    // Frame sequencer: arbitrate, load start address, walk words, terminate, retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant_r <= {NUM_REQ{1'b0}};
            addr_r  <= 9'd0;
            src_r   <= {SRC_W{1'b0}};
            rr_r    <= {SRC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            latch_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r <= pick_grant_s;
                        src_r   <= pick_idx_s;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    addr_r  <= sl_tail;
                    cnt_r   <= {CNT_W{1'b0}};
                    err_r   <= 1'b0;
                    state_r <= ST_READ;
                end
                ST_READ: begin
                    if (marker_s) begin
                        err_r   <= 1'b0;
                        state_r <= ST_EOF;
                    end else if (cnt_full_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_EOF;
                    end else if (xfer_s) begin
                        addr_r <= addr_r + 9'd1;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_EOF: begin
                    if (xfer_s) begin
                        latch_r <= 1'b1;
                        state_r <= ST_RETIRE;
                    end else begin
                        state_r <= ST_EOF;
                    end
                end
                ST_RETIRE: begin
                    latch_r <= 1'b0;
                    grant_r <= {NUM_REQ{1'b0}};
                    rr_r    <= rr_next_s;
                    state_r <= ST_IDLE;
                end
                default: begin
                    latch_r <= 1'b0;
                    grant_r <= {NUM_REQ{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sl_arb_grant  = grant_r;
    assign sl_addr       = addr_r;
    assign sl_latch_tail = latch_r;
    assign out_src       = src_r;
    assign out_data      = data_s;
    assign out_valid     = valid_s;
    assign out_last      = last_s;
    assign out_err       = err_s;

endmodule

// File: tb/tb_slave_bus_reader.sv
// Directed bench for slave_bus_reader: per-requester buffers modelled as
// small memories, one task per scenario with hand-computed expectations.
module tb_slave_bus_reader;

    localparam int NUM_REQ = 4;
    localparam int SRC_W   = 2;
    localparam int MAX_LEN = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_REQ-1:0] sl_arb_request = 4'b0000;
    logic [NUM_REQ-1:0] sl_arb_grant;
    logic [8:0]         sl_addr;
    logic [8:0]         sl_data;
    logic [8:0]         sl_tail;
    logic               sl_latch_tail;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [SRC_W-1:0]   out_src;
    logic               out_last;
    logic               out_err;

    logic [8:0] mem [NUM_REQ][512];
    logic [8:0] tail_tb [NUM_REQ];

    int checks   = 0;
    int failures = 0;

    int q_data[$];
    int q_src[$];
    int q_last[$];
    int q_err[$];
    int q_addr[$];
    int q_grant[$];
    int latch_cnt;
    int stall_bad;
    bit timed_out;

    slave_bus_reader #(
        .NUM_REQ      (NUM_REQ),
        .SRC_W        (SRC_W),
        .MAX_FRAME_LEN(MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sl_arb_request(sl_arb_request),
        .sl_arb_grant  (sl_arb_grant),
        .sl_addr       (sl_addr),
        .sl_data       (sl_data),
        .sl_tail       (sl_tail),
        .sl_latch_tail (sl_latch_tail),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_src       (out_src),
        .out_last      (out_last),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    // Granted requester's buffer drives the shared bus.
    always_comb begin
        sl_data = 9'h100;
        sl_tail = 9'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sl_arb_grant[i]) begin
                sl_data = mem[i][sl_addr];
                sl_tail = tail_tb[i];
            end
        end
    end

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    // Records beats, grants and retire pulses until nframes retire or budget expires.
    task automatic run_frames(input int nframes, input bit pattern_ready, input int budget);
        int frames;
        int cyc;
        bit prev_stall;
        int prev_data;
        logic [NUM_REQ-1:0] prev_grant;
        logic [15:0] pat;
        pat = 16'b0110_1001_1100_0101;
        q_data.delete(); q_src.delete(); q_last.delete();
        q_err.delete(); q_addr.delete(); q_grant.delete();
        latch_cnt = 0; stall_bad = 0; timed_out = 1'b0;
        frames = 0; cyc = 0; prev_stall = 1'b0; prev_data = 0;
        prev_grant = sl_arb_grant;
        while (frames < nframes && cyc < budget) begin
            @(negedge clk);
            out_ready = pattern_ready ? pat[cyc % 16] : 1'b1;
            #1;
            if (prev_stall && out_valid && (int'(out_data) != prev_data)) stall_bad++;
            if (sl_arb_grant != 4'b0000 && prev_grant == 4'b0000) q_grant.push_back(onehot_idx(sl_arb_grant));
            if (out_valid && out_ready) begin
                q_data.push_back(int'(out_data));
                q_src.push_back(int'(out_src));
                q_last.push_back(int'(out_last));
                q_err.push_back(int'(out_err));
                q_addr.push_back(int'(sl_addr));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            if (sl_latch_tail) begin
                frames++;
                latch_cnt++;
                if (frames == nframes) sl_arb_request = 4'b0000;
            end
            prev_grant = sl_arb_grant;
            cyc++;
        end
        if (frames < nframes) timed_out = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sl_arb_grant !== 4'b0000 || sl_addr !== 9'd0 || sl_latch_tail !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus grant=%b addr=%0d latch=%b exp 0000/0/0", sl_arb_grant, sl_addr, sl_latch_tail);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_err !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            failures++;
            $display("FAIL reset_stream valid=%b last=%b err=%b data=%h src=%0d exp all 0", out_valid, out_last, out_err, out_data, out_src);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int exp_d[4];
        int exp_l[4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h00};
        exp_l = '{0, 0, 0, 1};
        mem[0][10] = 9'h011; mem[0][11] = 9'h022; mem[0][12] = 9'h033; mem[0][13] = 9'h100;
        tail_tb[0] = 9'd10;
        @(negedge clk);
        sl_arb_request = 4'b0001;
        run_frames(1, 1'b0, 100);
        checks++;
        if (timed_out !== 1'b0 || q_data.size() != 4) begin
            failures++;
            $display("FAIL single_len beats=%0d timeout=%b exp 4 beats", q_data.size(), timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != exp_d[i] || q_src[i] != 0 || q_last[i] != exp_l[i] || q_err[i] != 0) begin
                    failures++;
                    $display("FAIL single_beat%0d data=%h src=%0d last=%0d err=%0d exp data=%h src=0 last=%0d err=0",
                             i, q_data[i], q_src[i], q_last[i], q_err[i], exp_d[i], exp_l[i]);
                end
            end
        end
        checks++;
        if (latch_cnt != 1 || q_grant.size() != 1) begin
            failures++;
            $display("FAIL single_retire latches=%0d grants=%0d exp 1/1", latch_cnt, q_grant.size());
        end
    endtask

    task automatic test_rr();
        int exp_g[4];
        int exp_d[8];
        int exp_s[8];
        // pointer sits at 1 after requester 0 retired, so requester 2 goes first
        exp_g = '{2, 0, 2, 0};
        exp_d = '{8'hBB, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00, 8'hAA, 8'h00};
        exp_s = '{2, 2, 0, 0, 2, 2, 0, 0};
        mem[0][20] = 9'h0AA; mem[0][21] = 9'h100; tail_tb[0] = 9'd20;
        mem[2][30] = 9'h0BB; mem[2][31] = 9'h100; tail_tb[2] = 9'd30;
        @(negedge clk);
        sl_arb_request = 4'b0101;
        run_frames(4, 1'b0, 200);
        checks++;
        if (timed_out !== 1'b0 || q_grant.size() != 4 || q_data.size() != 8) begin
            failures++;
            $display("FAIL rr_len grants=%0d beats=%0d timeout=%b exp 4/8", q_grant.size(), q_data.size(), timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < q_grant.size()) begin
                checks++;
                if (q_grant[i] != exp_g[i]) begin
                    failures++;
                    $display("FAIL rr_grant%0d got=%0d exp=%0d", i, q_grant[i], exp_g[i]);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != exp_d[i] || q_src[i] != exp_s[i] || q_last[i] != (i % 2)) begin
                    failures++;
                    $display("FAIL rr_beat%0d data=%h src=%0d last=%0d exp data=%h src=%0d last=%0d",
                             i, q_data[i], q_src[i], q_last[i], exp_d[i], exp_s[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_d[5];
        int exp_a[5];
        exp_d = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h00};
        exp_a = '{510, 511, 0, 1, 2};
        mem[1][510] = 9'h05A; mem[1][511] = 9'h05B; mem[1][0] = 9'h05C;
        mem[1][1] = 9'h05D; mem[1][2] = 9'h100;
        tail_tb[1] = 9'd510;
        @(negedge clk);
        sl_arb_request = 4'b0010;
        run_frames(1, 1'b0, 100);
        checks++;
        if (timed_out !== 1'b0 || q_data.size() != 5) begin
            failures++;
            $display("FAIL wrap_len beats=%0d timeout=%b exp 5", q_data.size(), timed_out);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != exp_d[i] || q_addr[i] != exp_a[i] || q_src[i] != 1 || q_err[i] != 0 || q_last[i] != (i == 4 ? 1 : 0)) begin
                    failures++;
                    $display("FAIL wrap_beat%0d data=%h addr=%0d src=%0d err=%0d last=%0d exp data=%h addr=%0d src=1 err=0",
                             i, q_data[i], q_addr[i], q_src[i], q_err[i], q_last[i], exp_d[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        mem[3][100] = 9'h001; mem[3][101] = 9'h002; mem[3][102] = 9'h003;
        mem[3][103] = 9'h004; mem[3][104] = 9'h005; mem[3][105] = 9'h100;
        tail_tb[3] = 9'd100;
        @(negedge clk);
        sl_arb_request = 4'b1000;
        run_frames(1, 1'b1, 200);
        checks++;
        if (timed_out !== 1'b0 || q_data.size() != 6) begin
            failures++;
            $display("FAIL stall_len beats=%0d timeout=%b exp 6", q_data.size(), timed_out);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != (i == 5 ? 0 : i + 1) || q_src[i] != 3 || q_last[i] != (i == 5 ? 1 : 0)) begin
                    failures++;
                    $display("FAIL stall_beat%0d data=%h src=%0d last=%0d exp data=%h src=3",
                             i, q_data[i], q_src[i], q_last[i], (i == 5 ? 0 : i + 1));
                end
            end
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL stall_stable changes=%0d exp 0", stall_bad);
        end
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 8; i++) mem[0][200 + i] = 9'h040 + 9'(i);
        tail_tb[0] = 9'd200;
        @(negedge clk);
        sl_arb_request = 4'b0001;
        run_frames(1, 1'b0, 100);
        checks++;
        if (timed_out !== 1'b0 || q_data.size() != MAX_LEN + 1) begin
            failures++;
            $display("FAIL trunc_len beats=%0d timeout=%b exp %0d", q_data.size(), timed_out, MAX_LEN + 1);
        end
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != (i == MAX_LEN ? 0 : 8'h40 + i) || q_src[i] != 0 ||
                    q_last[i] != (i == MAX_LEN ? 1 : 0) || q_err[i] != (i == MAX_LEN ? 1 : 0)) begin
                    failures++;
                    $display("FAIL trunc_beat%0d data=%h src=%0d last=%0d err=%0d exp data=%h last/err=%0d",
                             i, q_data[i], q_src[i], q_last[i], q_err[i], (i == MAX_LEN ? 0 : 8'h40 + i), (i == MAX_LEN ? 1 : 0));
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (sl_arb_grant !== 4'b0000 || latch_cnt != 1 || sl_latch_tail !== 1'b0) begin
            failures++;
            $display("FAIL trunc_release grant=%b latches=%0d latch=%b exp 0000/1/0", sl_arb_grant, latch_cnt, sl_latch_tail);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int cyc;
        mem[2][300] = 9'h071; mem[2][301] = 9'h072; mem[2][302] = 9'h073; mem[2][303] = 9'h100;
        tail_tb[2] = 9'd300;
        hit = 1'b0;
        cyc = 0;
        @(negedge clk);
        sl_arb_request = 4'b0100;
        while (!hit && cyc < 50) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid && out_data == 8'h72) hit = 1'b1;
            cyc++;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midrst_reach second byte not seen within 50 cycles");
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sl_arb_grant !== 4'b0000 || sl_addr !== 9'd0 || sl_latch_tail !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || out_src !== 2'd0 || out_last !== 1'b0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs grant=%b addr=%0d latch=%b valid=%b data=%h src=%0d last=%b err=%b exp all 0",
                     sl_arb_grant, sl_addr, sl_latch_tail, out_valid, out_data, out_src, out_last, out_err);
        end
        @(negedge clk);
        rst = 1'b1;
        run_frames(1, 1'b0, 100);
        checks++;
        if (timed_out !== 1'b0 || q_data.size() != 4) begin
            failures++;
            $display("FAIL midrst_len beats=%0d timeout=%b exp 4", q_data.size(), timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                checks++;
                if (q_data[i] != (i == 3 ? 0 : 8'h71 + i) || q_src[i] != 2 || q_last[i] != (i == 3 ? 1 : 0)) begin
                    failures++;
                    $display("FAIL midrst_beat%0d data=%h src=%0d last=%0d exp data=%h src=2",
                             i, q_data[i], q_src[i], q_last[i], (i == 3 ? 0 : 8'h71 + i));
                end
            end
        end
    endtask

    initial begin
        for (int r = 0; r < NUM_REQ; r++) begin
            tail_tb[r] = 9'd0;
            for (int a = 0; a < 512; a++) mem[r][a] = 9'h100;
        end
        test_reset();
        test_single();
        test_rr();
        test_wrap();
        test_stall();
        test_trunc();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
